// File: rtl/imem_loader.sv
// Instruction-memory responder: 256x9 (2^ADDR_W x 9) fetch RAM loaded from a host byte stream.
// Optional checksum stage enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] instruction_address,
  output logic [8:0]        instruction,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int RW    = (ADDR_W >= 8) ? ADDR_W + 1 : 9;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_LO, S_HI, S_CHK, S_RUN, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_LO, S_HI, S_RUN} state_t;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_wp;
  logic [RW-1:0]     r_remaining;
  logic [7:0]        r_lo;
  logic              r_ready;
  logic              r_cpu_reset;
  logic              r_done;
  logic [8:0]        r_mem [DEPTH];
  logic              w_accept;
  logic              w_we;
  logic [RW-1:0]     w_len_count;
  logic              w_ready_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_sum;
  logic              r_error;
`endif

  assign w_accept    = load_valid && r_ready;
  assign w_we        = w_accept && !load_start && (r_state == S_HI);
  assign w_len_count = (load_data == '0) ? RW'(DEPTH) : RW'(load_data);

  // load_start outranks any byte accepted in the same cycle
  always_comb begin
    w_next = r_state;
    if (load_start) begin
      w_next = S_LEN;
    end else if (w_accept) begin
      case (r_state)
        S_LEN:   w_next = S_LO;
        S_LO:    w_next = S_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_HI:    w_next = (r_remaining == RW'(1)) ? S_CHK : S_LO;
        S_CHK:   w_next = (r_sum == load_data) ? S_RUN : S_ERR;
`else
        S_HI:    w_next = (r_remaining == RW'(1)) ? S_RUN : S_LO;
`endif
        default: w_next = r_state;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign w_ready_next = (w_next == S_LEN) || (w_next == S_LO) ||
                        (w_next == S_HI) || (w_next == S_CHK);
`else
  assign w_ready_next = (w_next == S_LEN) || (w_next == S_LO) || (w_next == S_HI);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wp        <= '0;
      r_remaining <= '0;
      r_lo        <= '0;
      r_ready     <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum       <= '0;
      r_error     <= 1'b0;
`endif
    end else begin
      r_state     <= w_next;
      r_ready     <= w_ready_next;
      r_cpu_reset <= (w_next != S_RUN);
      r_done      <= (w_next == S_RUN);
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_error     <= (w_next == S_ERR);
      if (load_start) begin
        r_sum <= '0;
      end else if (w_accept && (r_state == S_LO || r_state == S_HI)) begin
        r_sum <= r_sum + load_data;
      end
`endif
      if (!load_start && w_accept) begin
        case (r_state)
          S_LEN: begin
            r_remaining <= w_len_count;
            r_wp        <= '0;
          end
          S_LO: r_lo <= load_data;
          S_HI: begin
            r_wp        <= r_wp + 1'b1;
            r_remaining <= r_remaining - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Memory has no reset so a partial or shorter program leaves older words intact
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wp] <= {load_data[0], r_lo};
    end
  end

  assign instruction = r_mem[instruction_address];
  assign load_ready  = r_ready;
  assign cpu_reset   = r_cpu_reset;
  assign load_done   = r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign load_error  = r_error;
`else
  assign load_error  = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected fetch words / status,
// a negedge monitor pops and compares. Follows IMEM_LOADER_CHECKSUM_EN if defined.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instruction_address = '0;
  logic [8:0] instruction;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_ready, cpu_reset, load_done, load_error;

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .instruction_address(instruction_address),
    .instruction(instruction), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .cpu_reset(cpu_reset),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  // status nibble = {load_error, load_done, cpu_reset, load_ready}
  localparam logic [3:0] ST_IDLE = 4'b0010;
  localparam logic [3:0] ST_LOAD = 4'b0011;
  localparam logic [3:0] ST_RUN  = 4'b0100;
  localparam logic [3:0] ST_ERR  = 4'b1010;

  typedef struct {
    int         kind;
    logic [8:0] exp;
    string      name;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  logic [8:0] act;
  logic       chk_req = 1'b0;
  int         checks = 0;
  int         failures = 0;

  logic [8:0] model_mem [256];
  bit         model_known [256];
  logic [8:0] prog [256];

  always @(negedge clk) begin
    if (chk_req) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow: got request, required queued entry");
      end else begin
        cur = sb.pop_front();
        act = (cur.kind == 0) ? instruction
                              : {5'b0, load_error, load_done, cpu_reset, load_ready};
        if (act !== cur.exp) begin
          failures++;
          $display("FAIL %s: got %h required %h", cur.name, act, cur.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_q(int kind, logic [8:0] exp, string name);
    sb.push_back('{kind, exp, name});
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic expect_status(logic [3:0] s, string name);
    expect_q(1, {5'b0, s}, name);
  endtask

  task automatic check_mem(string name);
    for (int a = 0; a < 256; a++) begin
      if (model_known[a]) begin
        instruction_address = 8'(a);
        expect_q(0, model_mem[a], $sformatf("%s_mem[%0d]", name, a));
      end
    end
  endtask

  task automatic send_byte(logic [7:0] b, bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        load_valid = 1'b0;
        load_data  = 8'($urandom);
        tick();
      end
    end
    load_valid = 1'b1;
    load_data  = b;
    for (int i = 0; i < 20; i++) begin
      if (load_ready) begin
        tick();
        return;
      end
      tick();
    end
    checks++;
    failures++;
    $display("FAIL byte_accept_timeout: got load_ready=0 for 20 cycles, required 1");
  endtask

  task automatic pulse_start(bit with_byte);
    load_start = 1'b1;
    load_valid = with_byte;
    load_data  = 8'h07;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
  endtask

  // Full load of prog[0..n-1]; n=256 is sent as LEN byte 00.
  task automatic do_load(int n, bit gaps, bit good_sum, bit drop_byte, string name);
    logic [7:0] sum;
    logic [7:0] lo, hi;
    logic [3:0] fin;
    sum = '0;
    fin = ST_RUN;
    pulse_start(drop_byte);
    expect_status(ST_LOAD, {name, "_started"});
    send_byte(8'(n), gaps);
    for (int i = 0; i < n; i++) begin
      lo = prog[i][7:0];
      hi = {7'($urandom), prog[i][8]};
      send_byte(lo, gaps);
      send_byte(hi, gaps);
      sum = sum + lo + hi;
      model_mem[i % 256]   = prog[i];
      model_known[i % 256] = 1'b1;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(good_sum ? sum : sum + 8'd1, gaps);
    if (!good_sum) fin = ST_ERR;
`else
    if (!good_sum) fin = ST_RUN;
`endif
    load_valid = 1'b0;
    expect_status(fin, {name, "_finished"});
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    expect_status(ST_IDLE, "reset_state");
    load_valid = 1'b1;
    load_data  = 8'h5A;
    repeat (4) tick();
    expect_status(ST_IDLE, "idle_ignores_valid");
    load_valid = 1'b0;

    prog[0] = 9'h134;
    prog[1] = 9'h056;
    do_load(2, 1'b0, 1'b1, 1'b0, "directed");
    instruction_address = 8'd1;
    expect_q(0, 9'h056, "directed_fetch1");
    instruction_address = 8'd0;
    expect_q(0, 9'h134, "directed_fetch0");

    for (int a = 0; a < 256; a++) model_known[a] = 1'b0;
    model_mem[0] = 9'h134;
    model_mem[1] = 9'h056;
    do_load(2, 1'b1, 1'b1, 1'b0, "gapped");
    check_mem("gapped");
    load_valid = 1'b1;
    repeat (5) begin
      load_data = 8'($urandom);
      tick();
    end
    load_valid = 1'b0;
    expect_status(ST_RUN, "run_ignores_bytes");
    check_mem("run_hold");

    for (int i = 0; i < 256; i++) prog[i] = 9'(i);
    do_load(256, 1'b0, 1'b1, 1'b0, "full256");
    check_mem("full256");

    // Partial load overwritten by a restart whose start cycle carries a byte.
    pulse_start(1'b0);
    send_byte(8'd3, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'hF0, 1'b0);
    model_mem[0] = 9'h1C3;
    model_mem[1] = 9'h0A5;
    send_byte(8'h11, 1'b0);
    prog[0] = 9'h1AA;
    do_load(1, 1'b0, 1'b1, 1'b1, "restart_drop");
    check_mem("restart_drop");

    // Reset after LEN/LO/HI: first word kept, IDLE immediately.
    pulse_start(1'b0);
    send_byte(8'd5, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h00, 1'b0);
    model_mem[0] = 9'h03C;
    load_valid = 1'b1;
    reset = 1'b1;
    expect_status(ST_IDLE, "mid_load_reset");
    load_valid = 1'b0;
    reset = 1'b0;
    tick();
    check_mem("after_reset");

    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) prog[i] = 9'($urandom);
      do_load(n, 1'b1, 1'b1, 1'b0, $sformatf("rand%0d", r));
      check_mem($sformatf("rand%0d", r));
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    prog[0] = 9'h110;
    do_load(1, 1'b0, 1'b0, 1'b0, "bad_sum");
    load_valid = 1'b1;
    repeat (3) tick();
    load_valid = 1'b0;
    expect_status(ST_ERR, "err_holds");
    do_load(1, 1'b0, 1'b1, 1'b0, "good_sum");
`endif

    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory responder for the 9-bit-instruction CPU core. It holds a 256 x 9 instruction RAM and answers the core's fetch port combinationally. It also receives a program as a byte stream over a valid/ready handshake while holding the core in reset, then releases the core to run from address 0. It sits between the board-level host link and the core's `instruction_address`/`instruction`/`reset` pins.

## Interface
Parameters:
- `ADDR_W`, default 8: fetch/write address width; memory depth is 2^ADDR_W words of 9 bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `instruction_address`  in  ADDR_W  fetch address from the core.
- `instruction`  out  9  word at `instruction_address`.
- `load_start`  in  1  single-cycle pulse; begins or restarts a program load.
- `load_valid`  in  1  host byte valid.
- `load_data`  in  8  host byte.
- `load_ready`  out  1  block accepts a byte this cycle.
- `cpu_reset`  out  1  reset to the core; high except in RUN.
- `load_done`  out  1  high in RUN.
- `load_error`  out  1  checksum failure flag (see Configuration).

## Operation
- Byte transfer occurs on a rising edge where `load_valid && load_ready`.
- States: IDLE, LEN, LO, HI, CHK (macro only), RUN, ERR (macro only).
- Transitions:
  - IDLE -> LEN on `load_start`.
  - LEN: the accepted byte sets the word count N. 0 means 2^ADDR_W. Loads a 9-bit `remaining`, clears write pointer `wp`, then goes to LO.
  - LO: the accepted byte is latched as `lo[7:0]`. Goes to HI.
  - HI: the accepted byte's bit 0 becomes instruction bit 8; bits 7:1 are ignored.
    - Writes `{byte[0], lo}` to `mem[wp]`, increments `wp` (wraps at 2^ADDR_W), and decrements `remaining`.
    - If `remaining` was 1, goes to RUN (CHK with the macro); otherwise goes to LO.
  - RUN: `load_start` goes to LEN. Any other input holds RUN.
- `load_start` in any state takes priority over a byte accepted in the same cycle: the byte is dropped and the state becomes LEN.
- Fetch: `instruction = mem[instruction_address]` is an asynchronous read in every state. A read on the cycle of a write to the same address returns the old word.
- Memory is not cleared by `reset`. Words beyond N keep their previous contents.
- Moore outputs, decoded from the registered state:
  - `load_ready` = state in {LEN, LO, HI, CHK}.
  - `cpu_reset` = state != RUN.
  - `load_done` = state == RUN.
  - `load_error` = state == ERR.

## Timing
- Reset (async): state IDLE, `wp`=0, `remaining`=0, `lo`=0. Outputs `cpu_reset`=1, `load_ready`=0, `load_done`=0, `load_error`=0.
- Reset mid-load aborts immediately to IDLE; the partial program remains in memory.
- The host may stream one byte per cycle; `load_ready` stays high for the whole load with no bubbles.
- Final HI byte accepted at edge k:
  - the word is written at edge k;
  - without the macro, `cpu_reset` falls and `load_done` rises right after edge k;
  - the core fetches address 0 first, since its PC was held in reset.
- `load_start` sampled at edge k: `cpu_reset` is high after edge k, and the LEN byte is accepted at edge k+1 or later.
- Total load for N words without the macro: 1 + 2N accepted bytes.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - after the last HI byte the block enters CHK and accepts one more byte;
  - the expected value is the 8-bit modulo-256 sum of every LO and HI byte of this load (the LEN byte is excluded);
  - the sum is cleared on entering LEN;
  - a match goes to RUN; a mismatch goes to ERR;
  - ERR holds `cpu_reset`=1 and `load_error`=1, and leaves only on `load_start` (to LEN) or `reset`.
- Macro undefined:
  - no CHK or ERR states and no sum register;
  - `load_error` is tied to 0;
  - the last HI byte goes straight to RUN.

## Test plan
- After reset, `cpu_reset`=1, `load_ready`=0, `load_done`=0. With `load_valid`=1 and no `load_start`, the state stays IDLE.
- `load_start`, then bytes 02, 34, 01, 56, 00 streamed back-to-back:
  - mem[0]=0x134 and mem[1]=0x056;
  - `cpu_reset` falls the cycle after the last byte;
  - `instruction_address`=1 reads 0x056.
- The same load with `load_valid` toggling every other cycle produces an identical memory image; bytes with `load_ready`=0 are never consumed.
- LEN byte 00 with 256 words of pattern i: mem[255]=255 and `wp` wraps to 0. In the middle of a second load, `load_start` asserted together with a valid byte drops that byte and the state returns to LEN.
- Reset asserted after 3 bytes of a load: IDLE immediately, `cpu_reset`=1, and words written earlier are unchanged.
- With `IMEM_LOADER_CHECKSUM_EN`, load 01, 10, 01:
  - checksum byte 11 -> RUN;
  - checksum byte 12 -> `load_error`=1 and `cpu_reset`=1 until `load_start`.
